// File: rtl/mips_pkg.sv
// Shared fetch-side definitions for the IF PC redirect controller.
//   OPC_BEQ       : opcode of beq
//   PC_INC        : sequential fetch increment in bytes
//   fetch_state_t : fetch FSM state encoding
//   is_beq()      : opcode decode helper for the IF decode logic
package mips_pkg;

  localparam logic [5:0] OPC_BEQ = 6'b000100;
  localparam int unsigned PC_INC = 4;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_t;

  function automatic logic is_beq(input logic [5:0] opcode);
    return (opcode == OPC_BEQ);
  endfunction

endpackage

// File: rtl/if_pc_redirect_ctrl_if.sv
// Bundle of the signals exchanged between the fetch redirect controller and
// the surrounding pipeline (branch handler, hazard unit, IF/ID register).
//   master : pipeline side, drives branch/hazard info, observes PC and IF/ID control
//   slave  : controller side
// Parameters: PC_W (address width), CNT_W (statistics counter width).
interface if_pc_redirect_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);

  logic             brnch_instr_IF;
  logic [15:0]      branch_imm_IF;
  logic             br_prediction;
  logic             flush;
  logic             branch_hazard_stall;
  logic             load_use_stall;
  logic [PC_W-1:0]  pc_IF;
  logic             IFID_write_en;
  logic             IFID_flush;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispred_count;

  modport master (
    output brnch_instr_IF, branch_imm_IF, br_prediction, flush,
           branch_hazard_stall, load_use_stall,
    input  pc_IF, IFID_write_en, IFID_flush, branch_count, mispred_count
  );

  modport slave (
    input  brnch_instr_IF, branch_imm_IF, br_prediction, flush,
           branch_hazard_stall, load_use_stall,
    output pc_IF, IFID_write_en, IFID_flush, branch_count, mispred_count
  );

endinterface

// File: rtl/br_target_calc.sv
// Combinational next-address arithmetic for the fetch stage.
//   pc   : current fetch address
//   imm  : raw 16-bit branch immediate of the IF instruction
//   pred : predicted-taken for the IF branch
//   seq  : pc + 4
//   tgt  : seq + (sign-extended imm << 2)
//   alt  : address of the path NOT being fetched (recovery address)
// All sums wrap modulo 2^PC_W.
module br_target_calc
  import mips_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] pc,
  input  logic [15:0]     imm,
  input  logic            pred,
  output logic [PC_W-1:0] seq,
  output logic [PC_W-1:0] tgt,
  output logic [PC_W-1:0] alt
);

  logic [PC_W-1:0] offset;

  assign offset = {{(PC_W-16){imm[15]}}, imm} << 2;
  assign seq    = pc + PC_W'(PC_INC);
  assign tgt    = seq + offset;
  assign alt    = pred ? seq : tgt;

endmodule

// File: rtl/if_pc_redirect_ctrl.sv
// IF-stage PC owner and fetch redirect controller.
// Selects the next fetch address (sequential, predicted-taken target or
// mispredict recovery), carries each fetched beq's alternate-path address
// into ID, and drives IF/ID write-enable and flush.
// Ports:
//   clk   : core clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of if_pc_redirect_ctrl_if (branch/hazard inputs,
//           pc_IF, IFID_write_en, IFID_flush, statistics counters)
// Optional build macro: BR_PRED_STATS_EN enables the branch/mispredict
// counters; otherwise both counter outputs are tied to zero.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | normal fetch, flush from ID may redirect
// STALL    | IF and ID held by a hazard stall
// REDIRECT | first cycle after a redirect; ID holds a bubble, flush ignored
module if_pc_redirect_ctrl
  import mips_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  if_pc_redirect_ctrl_if.slave bus
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] rec_pc_ID;
  logic            rec_valid_ID;
  logic [PC_W-1:0] seq;
  logic [PC_W-1:0] tgt;
  logic [PC_W-1:0] alt;
  logic [PC_W-1:0] next_pc;
  logic            stall;
  logic            flush_acc;

  br_target_calc #(.PC_W(PC_W)) u_calc (
    .pc   (pc),
    .imm  (bus.branch_imm_IF),
    .pred (bus.br_prediction),
    .seq  (seq),
    .tgt  (tgt),
    .alt  (alt)
  );

  assign stall = bus.branch_hazard_stall | bus.load_use_stall;

  // A flush only counts when ID really holds a branch and is not a bubble
  // inserted by the previous redirect; a stall drops it (handler re-asserts).
  assign flush_acc = bus.flush & rec_valid_ID & ~stall & (state != REDIRECT);

  // The squashed IF instruction's prediction is ignored on an accepted flush.
  always_comb begin
    next_pc = seq;
    if (stall)
      next_pc = pc;
    else if (flush_acc)
      next_pc = rec_pc_ID;
    else if (bus.brnch_instr_IF && bus.br_prediction)
      next_pc = tgt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      rec_pc_ID    <= '0;
      rec_valid_ID <= 1'b0;
    end else begin
      pc <= next_pc;
      if (!stall) begin
        if (flush_acc) begin
          rec_valid_ID <= 1'b0;
        end else begin
          rec_pc_ID    <= alt;
          rec_valid_ID <= bus.brnch_instr_IF;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (stall)
            state <= STALL;
          else if (flush_acc)
            state <= REDIRECT;
        end
        STALL: begin
          if (!stall)
            state <= flush_acc ? REDIRECT : FETCH;
        end
        REDIRECT: begin
          state <= stall ? STALL : FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign bus.pc_IF         = pc;
  assign bus.IFID_write_en = ~stall;
  assign bus.IFID_flush    = flush_acc;

`ifdef BR_PRED_STATS_EN
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  // Both counters saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (rec_valid_ID && !stall && (branch_cnt != '1))
        branch_cnt <= branch_cnt + CNT_W'(1);
      if (flush_acc && (mispred_cnt != '1))
        mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

  assign bus.branch_count  = branch_cnt;
  assign bus.mispred_count = mispred_cnt;
`else
  assign bus.branch_count  = {CNT_W{1'b0}};
  assign bus.mispred_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_if_pc_redirect_ctrl.sv
// Directed bench for if_pc_redirect_ctrl: hand-computed PC sequences,
// prediction redirects, mispredict recovery, stall/flush interaction,
// async reset and address wrap.
module tb_if_pc_redirect_ctrl;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  if_pc_redirect_ctrl_if #(.PC_W(32), .CNT_W(16)) bus ();

  if_pc_redirect_ctrl #(.PC_W(32), .RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic br, input logic [15:0] imm, input logic pred,
                       input logic fl, input logic bhs, input logic lus);
    bus.brnch_instr_IF      = br;
    bus.branch_imm_IF       = imm;
    bus.br_prediction       = pred;
    bus.flush               = fl;
    bus.branch_hazard_stall = bhs;
    bus.load_use_stall      = lus;
  endtask

  task automatic chk_cnt(input string tag, input int b, input int m);
`ifdef BR_PRED_STATS_EN
    chk({tag, "_bcnt"}, 32'(bus.branch_count), 32'(b));
    chk({tag, "_mcnt"}, 32'(bus.mispred_count), 32'(m));
`else
    chk({tag, "_bcnt"}, 32'(bus.branch_count), 32'h0);
    chk({tag, "_mcnt"}, 32'(bus.mispred_count), 32'h0);
    if (b < 0 || m < 0) $display("note: negative count requested");
`endif
  endtask

  initial begin
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    chk("rst_pc", bus.pc_IF, 32'h0);
    chk("rst_we", 32'(bus.IFID_write_en), 32'h1);
    chk("rst_fl", 32'(bus.IFID_flush), 32'h0);
    rst_n = 1'b1;
    step();
    chk("seq_4", bus.pc_IF, 32'h4);

    // Predicted-taken beq at 0x04 (imm 3): tgt = 0x08 + 0x0C = 0x14
    // Then sequential up to 0x10 via short route instead: reset first.
    // Walk sequentially 0x04 -> 0x40, then async reset mid-cycle.
    repeat (15) step();
    chk("seq_40", bus.pc_IF, 32'h40);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc", bus.pc_IF, 32'h0);
    chk("async_rst_st", 32'(dut.state), 32'(FETCH));
    chk_cnt("async_rst", 0, 0);
    #2;
    rst_n = 1'b1;

    // beq at 0x0, imm 0xFFFE, taken: tgt = 0x4 - 8 wraps to 0xFFFF_FFFC
    drive(1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("neg_tgt_wrap", bus.pc_IF, 32'hFFFF_FFFC);
    chk("neg_rec_pc", dut.rec_pc_ID, 32'h4);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("seq_wrap", bus.pc_IF, 32'h0);
    repeat (4) step();
    chk("seq_10", bus.pc_IF, 32'h10);

    // beq at 0x10 imm 3 predicted taken: 0 bubbles, target 0x20, alt 0x14
    drive(1'b1, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("pred_tgt", bus.pc_IF, 32'h20);
    chk("pred_rec", dut.rec_pc_ID, 32'h14);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("pred_nobubble", 32'(bus.IFID_flush), 32'h0);
    step();
    chk("pred_seq", bus.pc_IF, 32'h24);
    chk_cnt("pred", 2, 0);

    // Back to 0x10 via reset, then not-taken beq that mispredicts
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    repeat (4) step();
    chk("seq_10b", bus.pc_IF, 32'h10);
    drive(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("nt_seq", bus.pc_IF, 32'h14);
    chk("nt_rec", dut.rec_pc_ID, 32'h20);
    drive(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("mis_flush", 32'(bus.IFID_flush), 32'h1);
    chk("mis_we", 32'(bus.IFID_write_en), 32'h1);
    step();
    chk("mis_pc", bus.pc_IF, 32'h20);
    chk("mis_state", 32'(dut.state), 32'(REDIRECT));
    chk_cnt("mis", 1, 1);
    // flush held high during REDIRECT is ignored
    chk("redir_noflush", 32'(bus.IFID_flush), 32'h0);
    step();
    chk("redir_seq", bus.pc_IF, 32'h24);
    chk("redir_state", 32'(dut.state), 32'(FETCH));

    // beq at 0x24 imm 0x36 taken: 0x28 + 0xD8 = 0x100
    drive(1'b1, 16'h0036, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("jmp_100", bus.pc_IF, 32'h100);
    // beq at 0x100 imm 0xFFFE taken: 0x104 - 8 = 0xFC, alt 0x104
    drive(1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("back_fc", bus.pc_IF, 32'hFC);
    chk("back_rec", dut.rec_pc_ID, 32'h104);
    drive(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("back_flush", 32'(bus.IFID_flush), 32'h1);
    step();
    chk("back_recover", bus.pc_IF, 32'h104);
    chk_cnt("back", 3, 2);

    // beq at 0x104 imm 3 not taken: seq 0x108, alt 0x114
    drive(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("st_seq", bus.pc_IF, 32'h108);
    // flush together with stall: stall wins
    drive(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    chk("st_we", 32'(bus.IFID_write_en), 32'h0);
    chk("st_noflush", 32'(bus.IFID_flush), 32'h0);
    step();
    chk("st_hold", bus.pc_IF, 32'h108);
    chk("st_state", 32'(dut.state), 32'(STALL));
    step();
    chk("st_hold2", bus.pc_IF, 32'h108);
    drive(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("rel_flush", 32'(bus.IFID_flush), 32'h1);
    step();
    chk("rel_pc", bus.pc_IF, 32'h114);
    chk("rel_state", 32'(dut.state), 32'(REDIRECT));

    // load-use stall holds PC
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("lu_we", 32'(bus.IFID_write_en), 32'h0);
    step();
    chk("lu_hold", bus.pc_IF, 32'h114);
    chk("lu_state", 32'(dut.state), 32'(STALL));
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("lu_rel", bus.pc_IF, 32'h118);
    chk("lu_fetch", 32'(dut.state), 32'(FETCH));

    // flush with no branch in ID is ignored
    drive(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("inv_noflush", 32'(bus.IFID_flush), 32'h0);
    step();
    chk("inv_seq", bus.pc_IF, 32'h11C);
    chk("inv_state", 32'(dut.state), 32'(FETCH));
    chk_cnt("end", 4, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
